// File: rtl/sort_axil_pkg.sv
// Shared constants, FSM state type and saturating helpers for the sorter
// FIFO drain stage and its AXI4-Lite read port.
package sort_axil_pkg;

   localparam logic [31:0] ADDR_VAL_POP  = 32'h0000_0000;
   localparam logic [31:0] ADDR_IVAL_POP = 32'h0000_0004;
   localparam logic [31:0] ADDR_STATUS   = 32'h0000_0008;
   localparam logic [31:0] ADDR_DROP_CLR = 32'h0000_000C;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {IDLE, RESP} state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

endpackage

// File: rtl/sort_sync_fifo.sv
// Single-clock byte FIFO fed by the sorter; a push into a full FIFO is only
// accepted when a pop frees a slot in the same cycle, otherwise it is dropped.
module sort_sync_fifo #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic              drop
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_do_push, w_do_pop;

   assign full  = (r_count == CNT_W'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;
   assign dout  = r_mem[r_rd_ptr];

   // An empty FIFO never bypasses: the pop fails even if a push lands now.
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);
   assign drop      = push && !w_do_push;

   // NOTE: storage has no reset; pointers and count alone define validity.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
         else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/sort_fifo_axil_reader.sv
// Drain stage for the packet sorter: valid/invalid byte FIFOs popped by the
// host over an AXI4-Lite read channel, plus status and drop counters.
module sort_fifo_axil_reader
   import sort_axil_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              val_push,
   input  logic [DATA_W-1:0] val_din,
   input  logic              ival_push,
   input  logic [DATA_W-1:0] ival_din,
   input  logic [31:0]       ARADDR,
   input  logic              ARVALID,
   output logic              ARREADY,
   output logic [31:0]       RDATA,
   output logic [1:0]        RRESP,
   output logic              RVALID,
   input  logic              RREADY,
   output logic              val_full,
   output logic              val_empty,
   output logic              ival_full,
   output logic              ival_empty,
   output logic [CNT_W-1:0]  val_fifo_ctr,
   output logic [CNT_W-1:0]  ival_fifo_ctr
);

   state_t            r_state, w_state_nxt;
   logic [31:0]       r_rdata, w_rdata_nxt, w_status;
   logic [1:0]        r_rresp, w_rresp_nxt;
   logic [7:0]        r_val_drop, r_ival_drop;
   logic              w_ar_hs, w_val_pop, w_ival_pop, w_drop_clr;
   logic              w_val_drop, w_ival_drop;
   logic [DATA_W-1:0] w_val_head, w_ival_head;

   // Pops and the drop clear happen only at the AR handshake, never in RESP.
   assign w_ar_hs    = ARREADY && ARVALID;
   assign w_val_pop  = w_ar_hs && (ARADDR == ADDR_VAL_POP);
   assign w_ival_pop = w_ar_hs && (ARADDR == ADDR_IVAL_POP);
   assign w_drop_clr = w_ar_hs && (ARADDR == ADDR_DROP_CLR);

   sort_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_val_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (val_push),
      .din   (val_din),
      .pop   (w_val_pop),
      .dout  (w_val_head),
      .count (val_fifo_ctr),
      .full  (val_full),
      .empty (val_empty),
      .drop  (w_val_drop)
   );

   sort_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_ival_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ival_push),
      .din   (ival_din),
      .pop   (w_ival_pop),
      .dout  (w_ival_head),
      .count (ival_fifo_ctr),
      .full  (ival_full),
      .empty (ival_empty),
      .drop  (w_ival_drop)
   );

   assign w_status = {sat_add(r_val_drop, r_ival_drop), 4'h0,
                      ival_empty, ival_full, val_empty, val_full,
                      4'h0, 4'(ival_fifo_ctr), 4'h0, 4'(val_fifo_ctr)};

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_rdata_nxt = '0;
      w_rresp_nxt = RESP_OKAY;
      case (ARADDR)
         ADDR_VAL_POP: begin
            if (val_empty) w_rresp_nxt = RESP_SLVERR;
            else           w_rdata_nxt = 32'(w_val_head);
         end
         ADDR_IVAL_POP: begin
            if (ival_empty) w_rresp_nxt = RESP_SLVERR;
            else            w_rdata_nxt = 32'(w_ival_head);
         end
         ADDR_STATUS:   w_rdata_nxt = w_status;
         ADDR_DROP_CLR: w_rdata_nxt = {16'h0, r_ival_drop, r_val_drop};
         default:       w_rresp_nxt = RESP_DECERR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (ARVALID) w_state_nxt = RESP;
         RESP:    if (RREADY)  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ARREADY = (r_state == IDLE);
      RVALID  = (r_state == RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_rdata <= w_rdata_nxt;
         r_rresp <= w_rresp_nxt;
      end
   end

   // A clear wins over a drop arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || w_drop_clr) begin
         r_val_drop  <= '0;
         r_ival_drop <= '0;
      end else begin
         if (w_val_drop)  r_val_drop  <= sat_inc(r_val_drop);
         if (w_ival_drop) r_ival_drop <= sat_inc(r_ival_drop);
      end
   end

   assign RDATA = r_rdata;
   assign RRESP = r_rresp;

endmodule

// File: tb/tb_sort_fifo_axil_reader.sv
// Directed-vector bench for sort_fifo_axil_reader: a table of reads/pushes
// with hand-computed results, plus stall and reset-in-RESP sequences.
module tb_sort_fifo_axil_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        val_push, ival_push;
   logic [7:0]  val_din, ival_din;
   logic [31:0] ARADDR;
   logic        ARVALID, ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID, RREADY;
   logic        val_full, val_empty, ival_full, ival_empty;
   logic [3:0]  val_fifo_ctr, ival_fifo_ctr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sort_fifo_axil_reader dut (
      .clk           (clk),
      .rst           (rst),
      .val_push      (val_push),
      .val_din       (val_din),
      .ival_push     (ival_push),
      .ival_din      (ival_din),
      .ARADDR        (ARADDR),
      .ARVALID       (ARVALID),
      .ARREADY       (ARREADY),
      .RDATA         (RDATA),
      .RRESP         (RRESP),
      .RVALID        (RVALID),
      .RREADY        (RREADY),
      .val_full      (val_full),
      .val_empty     (val_empty),
      .ival_full     (ival_full),
      .ival_empty    (ival_empty),
      .val_fifo_ctr  (val_fifo_ctr),
      .ival_fifo_ctr (ival_fifo_ctr)
   );

   typedef struct {
      logic        is_read;
      logic [31:0] addr;
      logic        vp;
      logic [7:0]  vd;
      logic        ip;
      logic [7:0]  id;
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
      logic [3:0]  exp_vc;
      logic [3:0]  exp_ic;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic void rdp(input logic [31:0] a, input logic vp, input logic [7:0] vd,
                               input logic ip, input logic [7:0] id, input logic [31:0] d,
                               input logic [1:0] r, input logic [3:0] vc, input logic [3:0] ic);
      vecs.push_back('{1'b1, a, vp, vd, ip, id, d, r, vc, ic});
   endfunction

   function automatic void rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r,
                              input logic [3:0] vc, input logic [3:0] ic);
      rdp(a, 1'b0, 8'h00, 1'b0, 8'h00, d, r, vc, ic);
   endfunction

   function automatic void psh(input logic vp, input logic [7:0] vd, input logic ip,
                               input logic [7:0] id, input logic [3:0] vc, input logic [3:0] ic);
      vecs.push_back('{1'b0, 32'h0, vp, vd, ip, id, 32'h0, 2'b00, vc, ic});
   endfunction

   // Full read transaction; pushes are driven in the AR handshake cycle.
   task automatic do_read(input logic [31:0] a, input logic vp, input logic [7:0] vd,
                          input logic ip, input logic [7:0] id,
                          output logic [31:0] d, output logic [1:0] r);
      @(negedge clk);
      check("arready_idle", ARREADY, 1);
      ARADDR = a; ARVALID = 1'b1;
      val_push = vp; val_din = vd; ival_push = ip; ival_din = id;
      @(negedge clk);
      ARVALID = 1'b0; ARADDR = '0; val_push = 1'b0; ival_push = 1'b0;
      check("rvalid_rise", RVALID, 1);
      check("arready_busy", ARREADY, 0);
      d = RDATA; r = RRESP;
      RREADY = 1'b1;
      @(negedge clk);
      RREADY = 1'b0;
      check("rvalid_fall", RVALID, 0);
   endtask

   task automatic do_push(input logic vp, input logic [7:0] vd, input logic ip, input logic [7:0] id);
      @(negedge clk);
      val_push = vp; val_din = vd; ival_push = ip; ival_din = id;
      @(negedge clk);
      val_push = 1'b0; ival_push = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  r;

      rst = 1'b1; val_push = 0; ival_push = 0; val_din = 0; ival_din = 0;
      ARADDR = 0; ARVALID = 0; RREADY = 0;

      rd(32'h00, 32'h0, 2'b10, 0, 0);
      rd(32'h04, 32'h0, 2'b10, 0, 0);
      rd(32'h08, 32'h000A_0000, 2'b00, 0, 0);
      psh(1, 8'hA5, 0, 0, 1, 0);
      psh(1, 8'h11, 0, 0, 2, 0);
      psh(1, 8'h22, 0, 0, 3, 0);
      rd(32'h08, 32'h0008_0003, 2'b00, 3, 0);
      rd(32'h00, 32'hA5, 2'b00, 2, 0);
      rd(32'h00, 32'h11, 2'b00, 1, 0);
      rd(32'h00, 32'h22, 2'b00, 0, 0);
      rd(32'h00, 32'h0, 2'b10, 0, 0);
      for (int i = 0; i < 10; i++) psh(0, 0, 1, 8'(i), 0, (i < 8) ? 4'(i + 1) : 4'd8);
      rd(32'h08, 32'h0206_0800, 2'b00, 0, 8);
      rd(32'h0C, 32'h0000_0200, 2'b00, 0, 8);
      rd(32'h0C, 32'h0, 2'b00, 0, 8);
      rd(32'h08, 32'h0006_0800, 2'b00, 0, 8);
      rdp(32'h04, 0, 0, 1, 8'h55, 32'h00, 2'b00, 0, 8);
      rd(32'h08, 32'h0006_0800, 2'b00, 0, 8);
      for (int i = 1; i < 8; i++) rd(32'h04, 32'(i), 2'b00, 0, 4'(8 - i));
      rd(32'h04, 32'h55, 2'b00, 0, 0);
      rd(32'h04, 32'h0, 2'b10, 0, 0);
      rdp(32'h04, 0, 0, 1, 8'h66, 32'h0, 2'b10, 0, 1);
      rd(32'h04, 32'h66, 2'b00, 0, 0);
      rd(32'h10, 32'h0, 2'b11, 0, 0);
      rd(32'h0C, 32'h0, 2'b00, 0, 0);
      for (int i = 0; i < 8; i++) psh(1, 8'(8'h80 + i), 0, 0, 4'(i + 1), 0);
      rd(32'h08, 32'h0009_0008, 2'b00, 8, 0);
      rdp(32'h0C, 1, 8'hEE, 0, 0, 32'h0, 2'b00, 8, 0);
      rd(32'h0C, 32'h0, 2'b00, 8, 0);
      psh(1, 8'hEE, 0, 0, 8, 0);
      rd(32'h08, 32'h0109_0008, 2'b00, 8, 0);

      repeat (2) @(negedge clk);
      check("rst_arready", ARREADY, 1);
      check("rst_rvalid", RVALID, 0);
      check("rst_rdata", RDATA, 0);
      check("rst_rresp", RRESP, 0);
      check("rst_flags", {val_full, val_empty, ival_full, ival_empty}, 4'b0101);
      check("rst_counts", {val_fifo_ctr, ival_fifo_ctr}, 8'h00);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].is_read) begin
            do_read(vecs[i].addr, vecs[i].vp, vecs[i].vd, vecs[i].ip, vecs[i].id, d, r);
            check($sformatf("v%0d_rdata@%h", i, vecs[i].addr), d, vecs[i].exp_d);
            check($sformatf("v%0d_rresp@%h", i, vecs[i].addr), 32'(r), 32'(vecs[i].exp_r));
         end else begin
            do_push(vecs[i].vp, vecs[i].vd, vecs[i].ip, vecs[i].id);
         end
         check($sformatf("v%0d_val_ctr", i), 32'(val_fifo_ctr), 32'(vecs[i].exp_vc));
         check($sformatf("v%0d_ival_ctr", i), 32'(ival_fifo_ctr), 32'(vecs[i].exp_ic));
      end

      // RREADY stall with ARVALID kept high: response frozen, one pop only.
      @(negedge clk);
      ARADDR = 32'h00; ARVALID = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("stall%0d_rvalid", k), RVALID, 1);
         check($sformatf("stall%0d_rdata", k), RDATA, 32'h80);
         check($sformatf("stall%0d_rresp", k), 32'(RRESP), 0);
         check($sformatf("stall%0d_arready", k), ARREADY, 0);
         check($sformatf("stall%0d_val_ctr", k), 32'(val_fifo_ctr), 7);
         @(negedge clk);
      end
      ARVALID = 1'b0; RREADY = 1'b1;
      @(negedge clk);
      RREADY = 1'b0;
      check("stall_end_rvalid", RVALID, 0);
      check("stall_end_val_ctr", 32'(val_fifo_ctr), 7);

      // Reset while a response is pending.
      @(negedge clk);
      ARADDR = 32'h00; ARVALID = 1'b1;
      @(negedge clk);
      ARVALID = 1'b0;
      check("resp_pre_rst_rdata", RDATA, 32'h81);
      check("resp_pre_rst_val_ctr", 32'(val_fifo_ctr), 6);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_rvalid", RVALID, 0);
      check("mid_rst_arready", ARREADY, 1);
      check("mid_rst_rdata", RDATA, 0);
      check("mid_rst_counts", {val_fifo_ctr, ival_fifo_ctr}, 8'h00);
      check("mid_rst_flags", {val_full, val_empty, ival_full, ival_empty}, 4'b0101);

      do_read(32'h0C, 0, 0, 0, 0, d, r);
      check("post_rst_drops", d, 32'h0);
      do_read(32'h08, 0, 0, 0, 0, d, r);
      check("post_rst_status", d, 32'h000A_0000);
      do_read(32'h00, 0, 0, 0, 0, d, r);
      check("post_rst_pop_rresp", 32'(r), 32'h2);
      check("post_rst_pop_rdata", d, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sort_fifo_axil_reader.md
Name: sort_fifo_axil_reader

Overview:
- Downstream drain stage for the packet validator/sorter.
- Holds the valid-packet and invalid-packet byte FIFOs that the sorter pushes into, and exposes them to the host over an AXI4-Lite read channel.
- Provides pop-on-read data registers and a status register with occupancy and drop counts.
- Read channel only; no write channel.

Parameters:
- DEPTH, 8, entries per FIFO; power of two.
- DATA_W, 8, FIFO entry width; packet byte taken from WDATA[31:24] upstream.
- CNT_W, 4, occupancy counter width; must hold 0..DEPTH.

Ports:
- clk  in  1  sole clock
- rst  in  1  reset
- val_push  in  1  sorter pushes a valid-packet byte this cycle
- val_din  in  DATA_W  valid-packet byte
- ival_push  in  1  sorter pushes an invalid-packet byte this cycle
- ival_din  in  DATA_W  invalid-packet byte
- ARADDR  in  32  read address
- ARVALID  in  1  master address valid
- ARREADY  out  1  slave accepts address
- RDATA  out  32  read data
- RRESP  out  2  read response
- RVALID  out  1  read data valid
- RREADY  in  1  master accepts data
- val_full, val_empty, ival_full, ival_empty  out  1 each  FIFO flags, combinational from counts
- val_fifo_ctr, ival_fifo_ctr  out  CNT_W  occupancy

Interface rule (already decided): one clock, clk; reset rst is synchronous and active-high.

Behaviour:

Reset (rst=1 at posedge):
- FSM returns to IDLE; in-flight transaction discarded.
- ARREADY=1, RVALID=0, RDATA=0, RRESP=2'b00.
- Both pointers and counts = 0, so empty=1, full=0.
- Drop counters = 0.
- FIFO storage is not cleared.

FSM, two states:
- IDLE:
  - ARREADY=1.
  - On ARVALID: decode ARADDR, perform any pop, register RDATA/RRESP, set RVALID=1, ARREADY=0, go to RESP.
- RESP:
  - RDATA/RRESP/RVALID are held stable while RREADY=0.
  - On RREADY: RVALID=0, ARREADY=1, go to IDLE.
- Throughput and latency:
  - One read per two cycles at best.
  - RVALID rises on the cycle after the AR handshake.

Address map (full 32-bit exact match):
- 0x00: pop valid FIFO.
  - Non-empty: RDATA={24'h0, head}, RRESP=2'b00, read pointer and count advance.
  - Empty: RDATA=0, RRESP=2'b10 (SLVERR), no pop.
- 0x04: same as 0x00, for the invalid FIFO.
- 0x08: status, no side effects.
  - [3:0] val_fifo_ctr, [11:8] ival_fifo_ctr.
  - [16] val_full, [17] val_empty, [18] ival_full, [19] ival_empty.
  - [23:20] = 0.
  - [31:24] total drop count (val_drop + ival_drop), saturating at 8'hFF.
  - RRESP=2'b00.
- 0x0C: read-and-clear drop counters.
  - RDATA={16'h0, ival_drop, val_drop}, each 8-bit saturating; RRESP=2'b00.
  - Both counters zero next cycle.
  - A drop in the same cycle is lost; the counter still clears.
- Any other address: RDATA=0, RRESP=2'b11 (DECERR).

FIFO rules:
- Push accepted when count<DEPTH, or when a pop of the same FIFO occurs in the same cycle.
- Otherwise the push is dropped and the drop counter increments, saturating at 255.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Empty plus simultaneous push and pop: pop returns SLVERR, no bypass; the push is stored.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Count is held within 0..DEPTH.
- Pop occurs only at the AR handshake, never in RESP, so a stalled RREADY causes no further pops.

Decomposition:
- Shared package sort_axil_pkg:
  - Address constants ADDR_VAL_POP=32'h00, ADDR_IVAL_POP=32'h04, ADDR_STATUS=32'h08, ADDR_DROP_CLR=32'h0C.
  - RRESP constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - FSM state enum {IDLE, RESP}.
- Sub-module sort_sync_fifo (DEPTH, DATA_W):
  - Ports: push, din, pop, dout (head), count, full, empty, drop.
  - Instantiated twice: valid and invalid.

Test Plan:
- Reset, then read 0x00 and 0x04 → RVALID one cycle after handshake, RDATA=0, RRESP=2'b10 both; read 0x08 → RDATA=32'h000A_0000 (both empty).
- Push valid bytes A5,11,22; read 0x00 three times → RDATA=0xA5,0x11,0x22, RRESP=00; val_fifo_ctr 3→0; fourth read → SLVERR.
- Push 10 invalid bytes 0..9 → ival_full=1, ival_fifo_ctr=8; read 0x08 → [31:24]=2; read 0x0C → RDATA=32'h0000_0200; read again → 0; pops return 0..7 in order.
- ival full, pop 0x04 in the same cycle as ival_push of 0x55 → push accepted, count stays 8, no drop; the last pop returns 0x55.
- Hold RREADY=0 for 5 cycles after a 0x00 read → RDATA/RRESP stable, ARREADY=0, val count decremented once only.
- Read 0x10 → RRESP=2'b11, RDATA=0; assert rst during RESP → next cycle RVALID=0, ARREADY=1, counts=0.
